imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Boot-time program loader: the writer side of the instruction-memory write port.
//   Accepts a byte stream over a valid/ready handshake and packs each 4 bytes
//   little-endian into one 32-bit instruction word, then writes that word into
//   instruction memory with a one-cycle write strobe.
//   Holds the RV32I core in reset until the image is fully written.
// PARAMETERS
//   ADDR_W  10   byte-address width of instruction memory; word-aligned, low 2 bits always 0
//   WORDS   256  capacity in 32-bit words; a length header above this is rejected
// PORTS
//   clk         in   1       system clock, rising edge
//   Reset_n     in   1       asynchronous, active-low reset
//   start       in   1       one-cycle pulse: begin a load (ignored unless IDLE/DONE/ERROR)
//   byte_valid  in   1       source has a byte on byte_data
//   byte_data   in   8       stream byte
//   byte_ready  out  1       loader accepts byte this cycle
//   imem_we     out  1       instruction-memory write enable (one-cycle pulse)
//   imem_addr   out  ADDR_W  byte address of word being written
//   imem_wd     out  32      packed instruction word
//   core_reset  out  1       active-high reset to core; 1 until load completes
//   load_done   out  1       image written successfully (level)
//   load_err    out  1       load aborted (level)
// BEHAVIOUR
//   - Reset values: byte_ready=0, imem_we=0, imem_addr=0, imem_wd=0, core_reset=1,
//     load_done=0, load_err=0; FSM=IDLE; word counter=0, byte index=0.
//   - Byte transfer occurs on a rising clk where byte_valid && byte_ready; byte_data
//     is sampled only then. byte_ready is registered, a function of state only.
//   - Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes.
//   - FSM: IDLE -start-> LEN_LO -xfer-> LEN_HI -xfer-> (N==0: DONE; N>WORDS: ERROR;
//     else DATA). DATA -4th xfer-> WRITE. WRITE (1 cycle) -> DATA if words left, else DONE
//     (or CHK when the checksum option is compiled in). DONE/ERROR -start-> LEN_LO.
//   - byte_ready=1 in LEN_LO, LEN_HI, DATA (and CHK); 0 in IDLE, WRITE, DONE, ERROR.
//   - Packing: byte k of word (k=0..3) lands in imem_wd[8k+7:8k]; byte 0 is bits [7:0].
//   - Write latency: imem_we=1 for exactly the one cycle after the 4th byte transfer,
//     with imem_addr/imem_wd stable that cycle. No transfer is possible in WRITE.
//   - imem_addr starts at 0 on each start and advances by 4 after each write.
//     N<=WORDS guarantees no wrap; wrap-around never occurs.
//   - core_reset: 1 from reset and from any start; drops to 0 on entry to DONE; stays 0
//     in DONE. ERROR keeps core_reset=1.
//   - load_done=1 only in DONE; load_err=1 only in ERROR; both clear on start.
//   - start while in LEN_LO..WRITE/CHK: ignored; the load in progress continues.
//   - Reset_n low at any time, including mid-word or during WRITE: immediate return to
//     reset values; the partial word is discarded and imem_we drops asynchronously.
//   - byte_valid gaps of any length are tolerated; there is no timeout.
// CONFIGURATION
//   IMEM_LOADER_CHECKSUM_EN defined: after the last WRITE the FSM enters CHK and accepts one
//     byte, which must equal the XOR of all LEN and data bytes. Match -> DONE; mismatch ->
//     ERROR, core_reset stays 1. The N==0 case also passes through CHK.
//   Macro undefined: no CHK state; the last WRITE goes straight to DONE; the stream carries
//     no trailing byte.
// TESTING
//   - Reset: hold Reset_n=0 -> core_reset=1, byte_ready=0, imem_we=0, load_done=0, load_err=0.
//   - 2-word load: start; bytes 02 00 13 05 A0 00 93 05 B0 00 -> imem_we pulses at
//     addr 0x000 wd 0x00A00513 and addr 0x004 wd 0x00B00593; then load_done=1, core_reset=0.
//   - Throttled source: same image with byte_valid low 3 cycles between bytes -> identical
//     writes; byte_ready=0 during each WRITE cycle.
//   - Bounds: N=0 (00 00) -> DONE with no imem_we; N=257 (01 01) with WORDS=256 -> load_err=1,
//     no imem_we, core_reset=1.
//   - Abort: Reset_n low after 2 data bytes, then a new start with a 1-word image ->
//     single write at addr 0x000 with no stale bytes; start pulsed mid-load is ignored.
//   - Checksum (IMEM_LOADER_CHECKSUM_EN): 1-word image 01 00 13 00 00 00, trailing 12 -> DONE;
//     trailing 13 -> load_err=1, core_reset=1.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port shared by the loader
// (slave) and whatever sources the image / owns the memory (master).
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wd;

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output imem_we,
    output imem_addr,
    output imem_wd
  );

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wd
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: packs a length-prefixed byte stream into 32-bit words, writes them to
// instruction memory and holds the core in reset until done. Option: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int WORDS  = 256
) (
  input  logic            clk,
  input  logic            Reset_n,
  input  logic            start,
  imem_loader_if.slave    bus,
  output logic            core_reset,
  output logic            load_done,
  output logic            load_err
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERROR
  } state_t;

  localparam logic [16:0] WORDS_MAX = 17'(WORDS);

  state_t            state;
  state_t            state_nx;
  logic              xfer;
  logic              start_acc;
  logic [15:0]       len_word;

  logic [7:0]        len_lo;
  logic [15:0]       words_left;
  logic [1:0]        byte_idx;
  logic [23:0]       word_buf;

  logic              ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wd_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign bus.byte_ready = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wd    = wd_q;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    xfer      = bus.byte_valid && ready_q;
    len_word  = {bus.byte_data, len_lo};
    start_acc = start && (state == IDLE || state == DONE || state == ERROR);

    unique case (state)
      IDLE, DONE, ERROR: begin
        if (start_acc) state_nx = LEN_LO;
      end
      LEN_LO: begin
        if (xfer) state_nx = LEN_HI;
      end
      LEN_HI: begin
        if (xfer) begin
          if (len_word == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_nx = CHK;
`else
            state_nx = DONE;
`endif
          end else if ({1'b0, len_word} > WORDS_MAX) begin
            state_nx = ERROR;
          end else begin
            state_nx = DATA;
          end
        end
      end
      DATA: begin
        if (xfer && byte_idx == 2'd3) state_nx = WRITE;
      end
      WRITE: begin
        if (words_left == 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nx = CHK;
`else
          state_nx = DONE;
`endif
        end else begin
          state_nx = DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (xfer) state_nx = (bus.byte_data == csum) ? DONE : ERROR;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they are Moore functions of state.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      ready_q    <= (state_nx == LEN_LO) || (state_nx == LEN_HI) ||
                    (state_nx == DATA)   || (state_nx == CHK);
`else
      ready_q    <= (state_nx == LEN_LO) || (state_nx == LEN_HI) ||
                    (state_nx == DATA);
`endif
      we_q       <= (state_nx == WRITE);
      core_reset <= (state_nx != DONE);
      load_done  <= (state_nx == DONE);
      load_err   <= (state_nx == ERROR);
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      len_lo     <= '0;
      words_left <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      addr_q     <= '0;
      wd_q       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      if (start_acc) begin
        addr_q     <= '0;
        byte_idx   <= '0;
        words_left <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum       <= '0;
`endif
      end

      if (xfer && state == LEN_LO) begin
        len_lo <= bus.byte_data;
      end

      if (xfer && state == LEN_HI) begin
        words_left <= len_word;
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      if (xfer && (state == LEN_LO || state == LEN_HI || state == DATA)) begin
        csum <= csum ^ bus.byte_data;
      end
`endif

      // Fourth byte completes the word directly into the write-data register.
      if (xfer && state == DATA) begin
        byte_idx <= byte_idx + 2'd1;
        unique case (byte_idx)
          2'd0: word_buf[7:0]   <= bus.byte_data;
          2'd1: word_buf[15:8]  <= bus.byte_data;
          2'd2: word_buf[23:16] <= bus.byte_data;
          2'd3: wd_q            <= {bus.byte_data, word_buf};
          default: ;
        endcase
      end

      if (state == WRITE) begin
        addr_q     <= addr_q + ADDR_W'(4);
        words_left <= words_left - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a stream-level model queues expected memory writes,
// a monitor pops them as imem_we pulses. Honours IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

  logic clk = 1'b0;
  logic Reset_n = 1'b0;
  logic start = 1'b0;
  logic core_reset;
  logic load_done;
  logic load_err;

  imem_loader_if #(.ADDR_W(10)) bus ();

  imem_loader #(.ADDR_W(10), .WORDS(256)) dut (
    .clk        (clk),
    .Reset_n    (Reset_n),
    .start      (start),
    .bus        (bus.slave),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] wd;
  } wr_t;

  int errors = 0;
  int checks = 0;
  wr_t exp_q[$];
  logic [31:0] img[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (Reset_n && bus.imem_we === 1'b1) begin
      chk("ready_low_in_write", 32'(bus.byte_ready), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h wd %h expected no write",
                 bus.imem_addr, bus.imem_wd);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(bus.imem_addr), 32'(e.addr));
        chk("write_data", bus.imem_wd, e.wd);
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gmin, input int gmax);
    int gap;
    bit sent;
    gap = $urandom_range(gmax, gmin);
    bus.byte_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    sent = 1'b0;
    for (int i = 0; i < 200 && !sent; i++) begin
      @(negedge clk);
      if (bus.byte_ready === 1'b1) begin
        @(posedge clk); #1;
        sent = 1'b1;
      end
    end
    bus.byte_valid = 1'b0;
    if (!sent) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: got no byte_ready expected acceptance of %h", b);
    end
  endtask

  task automatic wait_end(input bit expect_err);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (load_done === 1'b1 || load_err === 1'b1) seen = 1'b1;
    end
    chk("load_done", 32'(load_done), 32'(!expect_err));
    chk("load_err", 32'(load_err), 32'(expect_err));
    chk("core_reset_end", 32'(core_reset), 32'(expect_err));
    chk("ready_end", 32'(bus.byte_ready), 32'd0);
    chk("missing_writes", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // Model: header N, then N words little-endian; word i lands at byte address 4*i.
  task automatic run_load(input int gmin, input int gmax, input bit bad_csum, input bit mid_start);
    logic [15:0] n;
    logic [7:0]  x;
    logic [7:0]  b;
    bit          exp_err;
    n = 16'(img.size());
    pulse_start();
    chk("start_core_reset", 32'(core_reset), 32'd1);
    chk("start_done_clear", 32'(load_done), 32'd0);
    chk("start_err_clear", 32'(load_err), 32'd0);
    for (int i = 0; i < img.size(); i++) exp_q.push_back({10'(4 * i), img[i]});
    x = n[7:0] ^ n[15:8];
    send_byte(n[7:0], gmin, gmax);
    send_byte(n[15:8], gmin, gmax);
    for (int i = 0; i < img.size(); i++) begin
      for (int k = 0; k < 4; k++) begin
        b = img[i][8*k +: 8];
        x = x ^ b;
        send_byte(b, gmin, gmax);
        if (mid_start && i == 0 && k == 1) pulse_start();
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? (x ^ 8'h01) : x, gmin, gmax);
    exp_err = bad_csum;
`else
    exp_err = 1'b0;
`endif
    wait_end(exp_err);
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_ready", 32'(bus.byte_ready), 32'd0);
    chk("rst_we", 32'(bus.imem_we), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_wd", bus.imem_wd, 32'd0);
    Reset_n = 1'b1;
    @(posedge clk); #1;

    img = '{32'h00A00513, 32'h00B00593};
    run_load(0, 0, 1'b0, 1'b0);

    run_load(3, 3, 1'b0, 1'b0);

    img = '{};
    run_load(0, 1, 1'b0, 1'b0);

    pulse_start();
    send_byte(8'h01, 0, 0);
    send_byte(8'h01, 0, 0);
    wait_end(1'b1);

    // Abort mid-word, then reload a single word.
    pulse_start();
    send_byte(8'h01, 0, 0);
    send_byte(8'h00, 0, 0);
    send_byte(8'hDE, 0, 0);
    send_byte(8'hAD, 0, 0);
    #2 Reset_n = 1'b0;
    #1;
    chk("abort_we", 32'(bus.imem_we), 32'd0);
    chk("abort_ready", 32'(bus.byte_ready), 32'd0);
    chk("abort_core_reset", 32'(core_reset), 32'd1);
    @(posedge clk); #1;
    Reset_n = 1'b1;
    @(posedge clk); #1;
    img = '{32'h00000093};
    run_load(0, 0, 1'b0, 1'b0);

    img = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    run_load(0, 2, 1'b0, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    img = '{32'h00000013};
    run_load(0, 0, 1'b0, 1'b0);
    run_load(0, 0, 1'b1, 1'b0);
`endif

    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(8, 1);
      img = '{};
      for (int i = 0; i < n; i++) img.push_back($urandom);
      run_load(0, 2, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    img = '{};
    for (int i = 0; i < 256; i++) img.push_back($urandom);
    run_load(0, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
